shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
//
// PURPOSE
//   Multi-cycle controller for a 64-bit left shift by a 6-bit amount.
//   Each cycle applies one fixed power-of-two shift (2^k) and retires one set bit of the amount.
//   Sits beside the execute stage; the pipeline hands it an operand and amount and stalls until the result is returned.
//   Valid/ready handshake on both the request and the result side.
//
// PARAMETERS
//   WIDTH   64               operand/result width; power of two, >= 2 (elaboration assert)
//   AMT_W   $clog2(WIDTH)    shift-amount width (6 at default)
//
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   in_valid   in   1       request present
//   in_ready   out  1       block can accept a request (high only in IDLE)
//   in_data    in   WIDTH   operand
//   in_amt     in   AMT_W   shift amount, 0..WIDTH-1
//   abort      in   1       synchronous flush: drop any operation in flight
//   out_valid  out  1       result held on out_data
//   out_ready  in   1       consumer takes the result
//   out_data   out  WIDTH   shifted result
//   busy       out  1       state != IDLE
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; data/amt regs=0; in_ready=1 after release; out_valid=0; out_data=0; busy=0.
//   - FSM states are IDLE, SHIFT and DONE.
//   - IDLE: on in_valid&in_ready at edge N:
//       - load data_r=in_data, rem_r=in_amt.
//       - next state = DONE if in_amt==0, else SHIFT.
//   - SHIFT: each edge, k = index of the highest set bit of rem_r.
//       - data_r <= data_r << 2^k (zero-fill); clear bit k of rem_r.
//       - When the updated rem_r==0, go to DONE.
//   - Latency: out_valid rises after edge N+popcount(in_amt); amt=0 gives out_valid after N.
//     Worst case is 6 cycles (amt=63).
//   - DONE: out_valid=1, out_data=data_r, both held stable until out_valid&out_ready.
//     Then go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
//   - Priority, highest first: rst_n, abort, handshake.
//   - abort in any state: next state IDLE, rem_r cleared, out_valid drops next cycle.
//     Any request presented in the same cycle is not accepted.
//   - abort while in DONE with out_ready=1: abort wins; the result is not considered delivered.
//   - in_valid while not IDLE: ignored; in_ready=0.
//   - Requester must hold in_data/in_amt stable until accepted.
//   - Arithmetic: bits shifted past WIDTH-1 are discarded; no carry/flag output.
//
// CONFIGURATION
//   SHIFT_SEQ_LSR_EN defined:
//     - adds input port dir (1 bit, sampled with the request; 0=LSL, 1=LSR).
//     - LSR zero-fills from the MSB side; same latency rules.
//   SHIFT_SEQ_LSR_EN undefined:
//     - dir port absent; LSL only; no LSR logic synthesised.
//
// STRUCTURE
//   Package shift_seq_pkg:
//     - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t
//     - localparam DEF_WIDTH = 64
//     - function msb_index(rem) returning the highest set bit
//   Sub-module pow2_shift_stage #(WIDTH, AMT_W):
//     - combinational; inputs data, one-hot k, optional dir.
//     - output is the data shifted by 2^k.
//     - built as a mux2_1 column per power of two.
//   Top level:
//     - FSM, data_r/rem_r registers, handshake logic.
//
// TESTING
//   1. in_data=5, in_amt=0 -> out_valid after edge N, out_data=5.
//   2. in_data=1, in_amt=63 -> 6 SHIFT cycles, out_data=0x8000_0000_0000_0000.
//   3. in_data=0x7FFF_FFFF_FFFF_FFFF, in_amt=2 -> 1 SHIFT cycle, out_data=0xFFFF_FFFF_FFFF_FFFC.
//   4. out_ready held 0 for 5 cycles in DONE -> out_valid/out_data stable, in_ready=0, new in_valid ignored.
//   5. abort (and separately rst_n=0) during SHIFT of amt=63 -> IDLE next cycle (reset: immediately).
//      out_valid never asserts; a following request amt=1 returns the correct result.
//   6. [SHIFT_SEQ_LSR_EN] dir=1, in_data=0x8000_0000_0000_0000, in_amt=63 -> out_data=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift_sequencer block.
// Optional feature macro: SHIFT_SEQ_LSR_EN (adds a logical-shift-right mode).
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam int DEF_WIDTH = 64;

  // Widest shift-amount field msb_index() can scan; the top checks AMT_W against it.
  localparam int MAX_AMT_W = 16;

  // Index of the highest set bit of rem; returns 0 when rem is all zeros.
  function automatic logic [7:0] msb_index(input logic [MAX_AMT_W-1:0] rem);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_AMT_W; i++) begin
      if (rem[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pow2_shift_stage.sv
// Combinational power-of-two shifter: shifts data by 2^k, where k is given one-hot.
// One mux2_1 column per power of two; with a one-hot select at most one column shifts.
// With SHIFT_SEQ_LSR_EN defined, dir_i selects LSL (0) or LSR (1); both zero-fill.
module pow2_shift_stage #(
  parameter int WIDTH = 64,
  parameter int AMT_W = 6
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] k_onehot_i,
`ifdef SHIFT_SEQ_LSR_EN
  input  logic             dir_i,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] col [AMT_W+1];

  assign col[0] = data_i;

  for (genvar i = 0; i < AMT_W; i++) begin : g_col
    logic [WIDTH-1:0] shifted;
`ifdef SHIFT_SEQ_LSR_EN
    assign shifted = dir_i ? (col[i] >> (2 ** i)) : (col[i] << (2 ** i));
`else
    assign shifted = col[i] << (2 ** i);
`endif
    // mux2_1: pass through unless this column's power of two is selected
    assign col[i+1] = k_onehot_i[i] ? shifted : col[i];
  end

  assign data_o = col[AMT_W];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 64-bit shifter controller: each SHIFT cycle retires the highest set
// bit k of the remaining amount by shifting the operand by 2^k.
// Optional feature macro: SHIFT_SEQ_LSR_EN (adds the dir port for LSR).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE; out_valid is high only in DONE, and out_data is held
// until out_valid&out_ready. abort outranks both handshakes and flushes to IDLE.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
`ifdef SHIFT_SEQ_LSR_EN
  input  logic             dir,
`endif
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output shift_state_t     dbg_state
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift_sequencer: WIDTH must be a power of two >= 2");
  end
  if (AMT_W > MAX_AMT_W) begin : g_bad_amt_w
    $error("shift_sequencer: AMT_W exceeds msb_index range");
  end

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] k_onehot;
  logic [7:0]       k_idx;
  logic [WIDTH-1:0] stage_out;
  logic             accept;
`ifdef SHIFT_SEQ_LSR_EN
  logic             dir_q, dir_d;
`endif

  // Pick the power of two to retire this cycle: highest set bit of the remaining amount
  always_comb begin
    k_idx    = msb_index(MAX_AMT_W'(rem_q));
    k_onehot = {{(AMT_W-1){1'b0}}, 1'b1} << k_idx;
  end

  pow2_shift_stage #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_stage (
    .data_i     (data_q),
    .k_onehot_i (k_onehot),
`ifdef SHIFT_SEQ_LSR_EN
    .dir_i      (dir_q),
`endif
    .data_o     (stage_out)
  );

  // A request is taken only in IDLE and never in a cycle where abort is high
  assign accept = (state_q == IDLE) && in_valid && !abort;

  // Datapath next-state: load on accept, shift and retire a bit in SHIFT, clear rem on abort
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
`ifdef SHIFT_SEQ_LSR_EN
    dir_d  = dir_q;
`endif
    if (abort) begin
      rem_d = '0;
    end else if (accept) begin
      data_d = in_data;
      rem_d  = in_amt;
`ifdef SHIFT_SEQ_LSR_EN
      dir_d  = dir;
`endif
    end else if (state_q == SHIFT) begin
      data_d = stage_out;
      rem_d  = rem_q & ~k_onehot;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rem_q  <= '0;
`ifdef SHIFT_SEQ_LSR_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
`ifdef SHIFT_SEQ_LSR_EN
      dir_q  <= dir_d;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: abort always returns to IDLE, even over a DONE handshake
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = (in_amt == '0) ? DONE : SHIFT;
        SHIFT:   if (rem_d == '0) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: decoded purely from the registered state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = data_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a table of {operand, amount, expected result,
// expected latency} plus hand-written sequences for hold, abort and reset corners.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [5:0]   in_amt;
  logic         dir;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;
  shift_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef SHIFT_SEQ_LSR_EN
    .dir       (dir),
`endif
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  amt;
    logic        dir;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accepting edge
  task automatic start_req(input logic [63:0] d, input logic [5:0] a, input logic dr);
    @(negedge clk);
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    dir      = dr;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    in_amt   = '0;
    dir      = 1'b0;
  endtask

  // Wait for out_valid counting edges since acceptance (bounded)
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Consume a result with out_ready and confirm return to IDLE
  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 0);
    chk("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run_op(input string name, input logic [63:0] d, input logic [5:0] a,
                        input logic dr, input logic [63:0] exp, input int lat);
    int cyc;
    start_req(d, a, dr);
    wait_result(cyc);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_data"}, out_data, exp);
    take_result();
  endtask

  initial begin
    int cyc;
    int ov_hits;

    vecs[0]  = '{64'h5, 6'd0, 1'b0, 64'h5, 0};
    vecs[1]  = '{64'h1, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 6};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 6'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1};
    vecs[3]  = '{64'h1, 6'd1, 1'b0, 64'h2, 1};
    vecs[4]  = '{64'hDEAD_BEEF_0123_4567, 6'd4, 1'b0, 64'hEADB_EEF0_1234_5670, 1};
    vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 1'b0, 64'hFFFF_FFFF_0000_0000, 1};
    vecs[6]  = '{64'h0123_4567_89AB_CDEF, 6'd8, 1'b0, 64'h2345_6789_ABCD_EF00, 1};
    vecs[7]  = '{64'h3, 6'd5, 1'b0, 64'h60, 2};
    vecs[8]  = '{64'h8000_0000_0000_0001, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 6};
    vecs[9]  = '{64'hF0, 6'd12, 1'b0, 64'hF_0000, 2};
    vecs[10] = '{64'hABCD, 6'd60, 1'b0, 64'hD000_0000_0000_0000, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    dir       = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].dir,
             vecs[i].exp, vecs[i].lat);
    end

    // DONE hold: result stable for 5 cycles, in_ready low, new requests ignored
    start_req(64'h0000_0000_0000_00C3, 6'd3, 1'b0);
    wait_result(cyc);
    chk("hold_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hFFFF_0000_FFFF_0000;
      in_amt   = 6'd7;
      @(negedge clk);
      chk($sformatf("hold_valid_c%0d", i), out_valid, 1);
      chk($sformatf("hold_data_c%0d", i), out_data, 64'h618);
      chk($sformatf("hold_in_ready_c%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    in_amt   = '0;
    take_result();
    @(negedge clk);
    chk("hold_no_late_accept", busy, 0);

    // Abort during SHIFT of amt=63: IDLE next cycle, no result ever produced
    start_req(64'h1, 6'd63, 1'b0);
    chk("abort_busy_shift", busy, 1);
    @(negedge clk);
    chk("abort_no_valid_early", out_valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    ov_hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) ov_hits++;
    end
    chk("abort_out_valid_never", 64'(ov_hits), 0);
    run_op("after_abort", 64'h0000_0000_0000_1234, 6'd1, 1'b0, 64'h2468, 1);

    // Reset during SHIFT: idle immediately, clean follow-up
    start_req(64'h1, 6'd63, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 64'h55, 6'd1, 1'b0, 64'hAA, 1);

    // Abort wins over a DONE handshake
    start_req(64'h9, 6'd0, 1'b0);
    chk("abort_done_valid", out_valid, 1);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_done_out_valid", out_valid, 0);
    chk("abort_done_idle", busy, 0);

    // Abort in IDLE blocks a same-cycle request
    in_valid = 1'b1;
    in_data  = 64'h7;
    in_amt   = 6'd3;
    abort    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_idle_not_accepted", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_idle_no_result", out_valid, 0);

`ifdef SHIFT_SEQ_LSR_EN
    run_op("lsr_63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'h1, 6);
    run_op("lsr_4", 64'hF0, 6'd4, 1'b1, 64'hF, 1);
    run_op("lsl_after_lsr", 64'hF0, 6'd4, 1'b0, 64'hF00, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
